// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: a CPU write to DMA_REG stalls the CPU and copies one 256-byte page into OAM_DATA.
// Optional macro OAM_DMA_ALIGN_EN inserts one ALIGN cycle when HALT lands on an odd CPU cycle.
module oam_dma_ctrl #(
    parameter int          RD_LAT   = 1,
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004
) (
    input  logic        Clk,
    input  logic        Res_n,
    input  logic        Enable,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr_n,
    input  logic [7:0]  cpu_do,
    input  logic [7:0]  bus_din,
    output logic        rdy,
    output logic        dma_own,
    output logic [15:0] dma_addr,
    output logic        dma_wr_n,
    output logic [7:0]  dma_do,
    output logic        busy
);

    localparam logic RC_LAST = 1'(RD_LAT);

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HALT, S_READ, S_WRITE} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic        rc;
    logic        parity;
    logic        last_rd;
    logic [15:0] addr_hold;
    logic [7:0]  do_hold;
    logic [7:0]  data_r;

    assign last_rd = (rc == RC_LAST);
    assign busy    = (state != S_IDLE);

`ifndef OAM_DMA_ALIGN_EN
    // Parity still runs so both builds share the same register set; only alignment reads it.
    logic unused_parity;
    assign unused_parity = parity;
`endif

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        dma_own   = 1'b0;
        dma_wr_n  = 1'b1;
        dma_addr  = addr_hold;
        dma_do    = do_hold;
        case (state)
            S_IDLE: begin
                rdy = 1'b1;
                if (!cpu_wr_n && cpu_addr == DMA_REG)
                    state_nxt = S_HALT;
            end
            S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                state_nxt = parity ? S_ALIGN : S_READ;
`else
                state_nxt = S_READ;
`endif
            end
`ifdef OAM_DMA_ALIGN_EN
            S_ALIGN: state_nxt = S_READ;
`endif
            S_READ: begin
                dma_own  = 1'b1;
                dma_addr = {page, idx};
                if (last_rd)
                    state_nxt = S_WRITE;
            end
            S_WRITE: begin
                dma_own   = 1'b1;
                dma_wr_n  = 1'b0;
                dma_addr  = OAM_DATA;
                dma_do    = data_r;
                state_nxt = (idx == 8'hFF) ? S_IDLE : S_READ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control state; the hold registers keep the last bus values visible while the bus is released.
    always_ff @(posedge Clk or negedge Res_n) begin
        if (!Res_n) begin
            state     <= S_IDLE;
            page      <= 8'h00;
            idx       <= 8'h00;
            rc        <= 1'b0;
            parity    <= 1'b0;
            addr_hold <= 16'h0000;
            do_hold   <= 8'h00;
        end else if (Enable) begin
            parity    <= ~parity;
            state     <= state_nxt;
            addr_hold <= dma_addr;
            do_hold   <= dma_do;
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_HALT) begin
                        page <= cpu_do;
                        idx  <= 8'h00;
                        rc   <= 1'b0;
                    end
                end
                S_READ:  rc <= last_rd ? 1'b0 : rc + 1'b1;
                S_WRITE: if (idx != 8'hFF) idx <= idx + 8'h01;
                default: ;
            endcase
        end
    end

    // Read data capture on the final READ cycle
    always_ff @(posedge Clk) begin
        if (Enable && state == S_READ && last_rd)
            data_r <= bus_din;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences the 256-byte sprite DMA triggered by a CPU write to $4014.
- Stalls the CPU via its Rdy input and takes ownership of the shared CPU data bus.
- Copies page $XX00-$XXFF from system RAM or PRG ROM into the PPU OAM data port $2004.
- Sits between the CPU core and the databus decoder. The top level muxes the address, write strobe and write data onto the bus whenever dma_own is high.

Parameters:
- RD_LAT, 1, memory read latency in enabled cycles (0 or 1). Synchronous system RAM and PRG ROM use 1.
- DMA_REG, 16'h4014, CPU address that triggers a transfer.
- OAM_DATA, 16'h2004, destination address written for every byte.

Ports:
- Clk  in  1  CPU clock (CLK_NES domain).
- Res_n  in  1  reset, asynchronous, active-low.
- Enable  in  1  CPU clock enable. All state advances only when Enable=1.
- cpu_addr  in  16  CPU address, low 16 bits of the CPU bus.
- cpu_wr_n  in  1  CPU R/W_n (0 = write).
- cpu_do  in  8  CPU write data.
- bus_din  in  8  decoded read data returned by the databus.
- rdy  out  1  to CPU Rdy. 0 stalls the CPU.
- dma_own  out  1  DMA drives the bus this cycle.
- dma_addr  out  16  DMA bus address.
- dma_wr_n  out  1  DMA R/W_n.
- dma_do  out  8  DMA write data.
- busy  out  1  transfer in progress (state != IDLE).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, rdy=1, dma_own=0, dma_addr=0, dma_wr_n=1, dma_do=0, busy=0, page=0, idx=0, parity=0.
- Parity register: toggles on every Enable=1 edge and is never held. 0 = even cycle.
- Trigger: in IDLE with Enable=1, cpu_wr_n=0 and cpu_addr==DMA_REG:
  - page <= cpu_do, idx <= 0, next state HALT.
  - The CPU write cycle itself completes normally.
  - rdy falls in the following cycle.
- States (transitions happen only on Enable=1 edges):
  - IDLE: rdy=1, dma_own=0.
  - HALT: one cycle; rdy=0, dma_own=0. Goes to ALIGN if the alignment rule fires (Optional Feature), else READ.
  - ALIGN: one dummy cycle; rdy=0, dma_own=0. Goes to READ.
  - READ: lasts 1+RD_LAT cycles (sub-counter rc). dma_own=1, dma_wr_n=1, dma_addr={page,idx}, held constant across all READ cycles. On the last READ cycle, data_r <= bus_din. Goes to WRITE.
  - WRITE: one cycle; dma_own=1, dma_wr_n=0, dma_addr=OAM_DATA, dma_do=data_r. If idx==8'hFF go to IDLE, else idx <= idx+1 and go to READ.
- Output defaults: dma_addr and dma_do hold their last values when dma_own=0. dma_wr_n=1 whenever the block is not in WRITE.
- idx is 8 bits and never wraps into the page. The page never increments, so $xxFF is followed by completion.
- Stall length (rdy=0 cycles): 1 + ALIGN + 256*(2+RD_LAT). That is 769 with RD_LAT=1 and no align, 770 with align.
- rdy returns to 1 in the cycle after the final WRITE.
- Write to DMA_REG while busy=1: ignored, page unchanged, no restart.
- Write to any other address: ignored.
- Enable=0: all registers frozen, outputs held, parity not toggled.
- Res_n low at any point: immediate return to reset values. A partial transfer is abandoned and not resumed after reset.
- The combinational outputs (rdy, dma_own, dma_wr_n) decode from registered state only, with no path from cpu_* inputs.

Optional Feature:
- Macro: OAM_DMA_ALIGN_EN.
- Defined: in HALT, if parity==1, insert ALIGN before READ. This reproduces the 513/514-cycle get/put alignment.
- Undefined: the ALIGN state is not compiled and HALT always goes directly to READ. Stall length is fixed at 1+256*(2+RD_LAT).

Test Plan:
- Basic transfer: RAM $0200+i = i^8'h5A, Enable=1, write $4014<=$02 on an even cycle.
  - rdy=0 for exactly 769 cycles.
  - 256 writes to $2004 carrying $5A,$5B,...,$A5 in order.
  - Read addresses run $0200-$02FF; busy clears with rdy.
- Alignment (OAM_DMA_ALIGN_EN defined): trigger so that HALT lands on parity=1 -> 770 stall cycles, with one ALIGN cycle where dma_own=0. Repeat with parity=0 -> 769.
- Enable gating: Enable toggles 1,0,1,0 during the transfer -> the byte sequence is identical to the basic test, dma_addr is stable across Enable=0 cycles, and the stall lasts 1538 Clk cycles.
- Ignored writes:
  - Writes to $4015 and $4013 in IDLE -> rdy stays 1, busy=0.
  - A write of $4014<=$07 forced while busy -> page stays $02.
- Reset mid-operation: assert Res_n=0 asynchronously at byte 100 -> rdy=1, dma_own=0, dma_wr_n=1 immediately. After release, a new $4014<=$03 transfer starts cleanly at $0300.
- Page $FF: $4014<=$FF with RD_LAT=1 -> reads $FF00-$FFFF from PRG ROM, 256 writes to $2004, then IDLE with no address wrap past $FFFF.
